// File: rtl/park_clark_sequencer.sv
// rtl/park_clark_sequencer.sv - inverse Park + inverse Clarke around one shared saturating multiplier
// Five sequenced multiplies per sample; results held in OUT until accepted downstream.
module park_clark_sequencer #(
  parameter int N       = 32,
  parameter int Q       = 18,
  parameter int SQRT3_2 = 227023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] id,
  input  logic [N-1:0] iq,
  input  logic [N-1:0] ctheta,
  input  logic [N-1:0] stheta,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ia,
  output logic [N-1:0] ib,
  output logic [N-1:0] ic,
  output logic         ovf
);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, MK, OUT} state_t;

  localparam logic signed [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N-1:0] KSQ  = N'(SQRT3_2);

  state_t state, state_nx;
  logic   xfer;

  logic signed [N-1:0] id_r, iq_r, c_r, s_r;
  logic signed [N-1:0] acc_a, acc_b, ialpha, ibeta;
  logic                ovf_acc;

  logic signed [N-1:0]   mul_a, mul_b, p, as_res, h, ib_nx, nk, ic_nx;
  logic signed [2*N-1:0] prod, prod_sh;
  logic                  p_ovf, as_ovf, ib_ovf, nk_ovf, ic_ovf;

  // Returns {overflow, saturated x+y or x-y}.
  function automatic logic [N:0] sat_sum(input logic signed [N-1:0] x,
                                         input logic signed [N-1:0] y,
                                         input logic sub);
    logic signed [N:0] r;
    if (sub) r = {x[N-1], x} - {y[N-1], y};
    else     r = {x[N-1], x} + {y[N-1], y};
    if (r[N] != r[N-1]) return {1'b1, (r[N] ? MINV : MAXV)};
    return {1'b0, r[N-1:0]};
  endfunction

  function automatic logic [N:0] sat_neg(input logic signed [N-1:0] x);
    if (x == MINV) return {1'b1, MAXV};
    return {1'b0, -x};
  endfunction

  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = (state == IDLE) | ((state == OUT) & out_ready);
    xfer     = in_valid & in_ready;
    case (state)
      IDLE:    if (xfer) state_nx = M0;
      M0:      state_nx = M1;
      M1:      state_nx = M2;
      M2:      state_nx = M3;
      M3:      state_nx = MK;
      MK:      state_nx = OUT;
      OUT:     if (out_ready) state_nx = in_valid ? M0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand steering for the single multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      M0:      begin mul_a = c_r; mul_b = id_r;  end
      M1:      begin mul_a = s_r; mul_b = iq_r;  end
      M2:      begin mul_a = s_r; mul_b = id_r;  end
      M3:      begin mul_a = c_r; mul_b = iq_r;  end
      MK:      begin mul_a = KSQ; mul_b = ibeta; end
      default: ;
    endcase
  end

  always_comb begin
    prod    = $signed({{N{mul_a[N-1]}}, mul_a}) * $signed({{N{mul_b[N-1]}}, mul_b});
    prod_sh = prod >>> Q;
    p_ovf   = (prod_sh[2*N-1:N-1] != {(N+1){prod_sh[2*N-1]}});
    p       = p_ovf ? (prod_sh[2*N-1] ? MINV : MAXV) : prod_sh[N-1:0];

    {as_ovf, as_res} = sat_sum((state == M1) ? acc_a : acc_b, p, (state == M1));

    // In MK, p is kb; the Clarke outputs are formed on the MK->OUT edge.
    h                = ialpha >>> 1;
    {ib_ovf, ib_nx}  = sat_sum(p, h, 1'b1);
    {nk_ovf, nk}     = sat_neg(p);
    {ic_ovf, ic_nx}  = sat_sum(nk, h, 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r    <= '0;
      iq_r    <= '0;
      c_r     <= '0;
      s_r     <= '0;
      acc_a   <= '0;
      acc_b   <= '0;
      ialpha  <= '0;
      ibeta   <= '0;
      ovf_acc <= 1'b0;
      ia      <= '0;
      ib      <= '0;
      ic      <= '0;
      ovf     <= 1'b0;
    end else begin
      if (xfer) begin
        id_r    <= id;
        iq_r    <= iq;
        c_r     <= ctheta;
        s_r     <= stheta;
        ovf_acc <= 1'b0;
      end
      case (state)
        M0: begin
          acc_a   <= p;
          ovf_acc <= ovf_acc | p_ovf;
        end
        M1: begin
          ialpha  <= as_res;
          ovf_acc <= ovf_acc | p_ovf | as_ovf;
        end
        M2: begin
          acc_b   <= p;
          ovf_acc <= ovf_acc | p_ovf;
        end
        M3: begin
          ibeta   <= as_res;
          ovf_acc <= ovf_acc | p_ovf | as_ovf;
        end
        MK: begin
          ia  <= ialpha;
          ib  <= ib_nx;
          ic  <= ic_nx;
          ovf <= ovf_acc | p_ovf | ib_ovf | nk_ovf | ic_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_park_clark_sequencer.sv
// tb/tb_park_clark_sequencer.sv - vector table, corner sequences and random samples vs reference model
module tb_park_clark_sequencer;

  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;
  localparam longint ONE  = 262144;
  localparam longint K    = 227023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] id = '0, iq = '0, ctheta = '0, stheta = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ia, ib, ic;
  logic        ovf;

  typedef struct {
    longint id, iq, c, s;
    longint ia, ib, ic, ov;
  } vec_t;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  m_ovf;
  vec_t tbl[6];

  park_clark_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .id(id), .iq(iq), .ctheta(ctheta), .stheta(stheta),
    .out_valid(out_valid), .out_ready(out_ready),
    .ia(ia), .ib(ib), .ic(ic), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic with clamping to 32-bit range.
  function automatic longint rsat(input longint v);
    if (v > MAXL) begin m_ovf = 1'b1; return MAXL; end
    if (v < MINL) begin m_ovf = 1'b1; return MINL; end
    return v;
  endfunction

  function automatic longint rmul(input longint a, input longint b);
    return rsat((a * b) >>> 18);
  endfunction

  function automatic vec_t ref_model(input vec_t v);
    vec_t   r;
    longint alpha, beta, kb, h;
    r     = v;
    m_ovf = 1'b0;
    alpha = rsat(rmul(v.c, v.id) - rmul(v.s, v.iq));
    beta  = rsat(rmul(v.s, v.id) + rmul(v.c, v.iq));
    kb    = rmul(K, beta);
    h     = alpha >>> 1;
    r.ia  = alpha;
    r.ib  = rsat(kb - h);
    r.ic  = rsat(rsat(-kb) - h);
    r.ov  = longint'(m_ovf);
    return r;
  endfunction

  function automatic longint rnd_val(input bit trig);
    if (trig) return longint'($urandom_range(0, 524288)) - ONE;
    if ($urandom_range(0, 3) == 0) return longint'($signed($urandom));
    return longint'($urandom_range(0, 2097152)) - 1048576;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v    = '{default: 0};
    v.id = rnd_val(1'b0);
    v.iq = rnd_val(1'b0);
    v.c  = rnd_val(1'b1);
    v.s  = rnd_val(1'b1);
    return ref_model(v);
  endfunction

  task automatic drive(input vec_t v);
    id     = 32'(v.id);
    iq     = 32'(v.iq);
    ctheta = 32'(v.c);
    stheta = 32'(v.s);
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, " ia"},  longint'($signed(ia)), v.ia);
    chk({tag, " ib"},  longint'($signed(ib)), v.ib);
    chk({tag, " ic"},  longint'($signed(ic)), v.ic);
    chk({tag, " ovf"}, longint'(ovf), v.ov);
  endtask

  // Called #1 after the accept edge; counts edges until out_valid.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 5);
  endtask

  task automatic run_sample(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, " in_ready"}, longint'(in_ready), 1);
    in_valid = 1'b1;
    drive(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    id = $urandom; iq = $urandom; ctheta = $urandom; stheta = $urandom;
    wait_result(tag);
    check_out(tag, v);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, longint'(out_valid), 0);
  endtask

  initial begin
    vec_t v;
    vec_t q[$];
    int   sent, got, last, hits;
    bit   stable;

    tbl[0] = '{ONE, 0, ONE, 0, ONE, -131072, -131072, 0};
    tbl[1] = '{0, ONE, ONE, 0, 0, 227023, -227023, 0};
    tbl[2] = '{0, ONE, 0, ONE, -ONE, 131072, 131072, 0};
    tbl[3] = '{8191 * ONE, -8191 * ONE, ONE, ONE, MAXL, -1073741823, -1073741823, 1};
    tbl[4] = '{ONE, 0, ONE, 0, ONE, -131072, -131072, 0};
    tbl[5] = '{MINL, 0, -ONE, 0, MAXL, -1073741823, -1073741823, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset ia", longint'(ia), 0);
    chk("reset ib", longint'(ib), 0);
    chk("reset ic", longint'(ic), 0);
    chk("reset ovf", longint'(ovf), 0);
    rst_n = 1'b1;
    #1 chk("post-reset in_ready", longint'(in_ready), 1);

    for (int i = 0; i < 6; i++) run_sample(tbl[i], $sformatf("vec%0d", i));

    // Result held while out_ready low; back-to-back accept on release
    @(negedge clk);
    in_valid = 1'b1;
    drive(tbl[1]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("hold first");
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || in_ready || $signed(ib) != 227023 || $signed(ic) != -227023) stable = 1'b0;
    end
    chk("hold stable", longint'(stable), 1);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(tbl[2]);
    #1 chk("hold release in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("hold b2b out_valid", longint'(out_valid), 0);
    wait_result("hold second");
    check_out("hold second", tbl[2]);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    for (int i = 0; i < 16; i++) run_sample(rnd_vec(), $sformatf("rnd%0d", i));

    // Streaming with out_ready high: one result every 6 cycles
    sent = 0; got = 0; last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      @(negedge clk);
      if (out_valid && q.size() > 0) begin
        check_out($sformatf("stream%0d", got), q[0]);
        void'(q.pop_front());
        if (last >= 0) chk("stream gap", cyc - last, 6);
        last = cyc;
        got++;
      end
      if (in_ready && sent < 5) begin
        v = rnd_vec();
        drive(v);
        q.push_back(v);
        in_valid = 1'b1;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream count", got, 5);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset while in M2 discards the sample
    @(negedge clk);
    in_valid = 1'b1;
    drive(tbl[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", longint'(out_valid), 0);
    chk("mid reset ia", longint'(ia), 0);
    chk("mid reset ib", longint'(ib), 0);
    chk("mid reset ic", longint'(ic), 0);
    chk("mid reset ovf", longint'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("after reset in_ready", longint'(in_ready), 1);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("no stale result", hits, 0);

    run_sample(tbl[2], "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
